// File: rtl/clk_gen_pkg.sv
// Shared definitions for the returned-clock monitor.
// Holds the monitor FSM state encoding, the alignment vector, and both
// expected-pattern tables. Vector bit order is
// {PCLK, nCLKEN, BCLK, CPUCLK, CLK90}, so bit 4 is PCLK and bit 0 is CLK90.
// It also holds the default lock length and the stall timeout.
package clk_gen_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } mon_state_t;

   // Phase 0 of both patterns; seeing it in SEARCH starts tracking.
   localparam logic [4:0] ALIGN_V = 5'b10101;

   localparam int LOCK_COUNT_DEF = 16;
   localparam int TIMEOUT_DEF    = 16;

   // Index [0] is phase 0 (the last element of each concatenation).
   localparam logic [3:0][4:0] PAT_MODE0 = {5'b00011, 5'b11010, 5'b01100, 5'b10101};
   localparam logic [7:0][4:0] PAT_MODE1 = {5'b00011, 5'b11011, 5'b01010, 5'b10010,
                                            5'b00100, 5'b11100, 5'b01101, 5'b10101};

endpackage

// File: rtl/clk_pattern_rom.sv
// Combinational lookup of the expected returned-clock vector.
// Ports:
//   mode  - 0 = 4-phase pattern (only phase[1:0] is used), 1 = 8-phase pattern
//   phase - phase index of the sample being checked
//   v     - expected {PCLK, nCLKEN, BCLK, CPUCLK, CLK90}
module clk_pattern_rom
   import clk_gen_pkg::*;
(
   input  logic       mode,
   input  logic [2:0] phase,
   output logic [4:0] v
);

   // Select the table row for the requested mode and phase.
   always_comb begin
      v = PAT_MODE0[phase[1:0]];
      if (mode) begin
         v = PAT_MODE1[phase];
      end else begin
         v = PAT_MODE0[phase[1:0]];
      end
   end

endmodule

// File: rtl/clock_monitor.sv
// Monitors the returned clock lines of a clock generator.
// The monitor finds the phase-0 alignment vector, verifies LOCK_COUNT
// consecutive phases against the expected pattern, and then reports lock.
// Once locked, any deviation is counted as a phase error.
// Ports:
//   in_clk      - sole clock, rising edge
//   reset       - synchronous, active-high reset
//   clk_select  - expected pattern: 0 = 4-phase, 1 = 8-phase
//   *_in        - returned clock lines, synchronous to in_clk
//   clear_err   - synchronous clear of err_count (wins over a same-cycle error)
//   locked      - pattern tracked and verified
//   phase_err   - one-cycle pulse per mismatch while locked
//   stalled     - no alignment seen within TIMEOUT search cycles
//   phase_idx   - phase of the sample currently held in the input stage
//   err_count   - saturating count of locked mismatches
// Pipeline: the pins are registered once, then the compare results are
// registered into the outputs, so the pin-to-output latency is 2 cycles.
module clock_monitor
   import clk_gen_pkg::*;
#(
   parameter int LOCK_COUNT = LOCK_COUNT_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int ERR_W      = 8
) (
   input  logic             in_clk,
   input  logic             reset,
   input  logic             clk_select,
   input  logic             PCLK_in,
   input  logic             nCLKEN_in,
   input  logic             BCLK_in,
   input  logic             CPUCLK_in,
   input  logic             CLK90_in,
   input  logic             clear_err,
   output logic             locked,
   output logic             phase_err,
   output logic             stalled,
   output logic [2:0]       phase_idx,
   output logic [ERR_W-1:0] err_count
);

   localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
   localparam int SEARCH_W = $clog2(TIMEOUT + 1);
   localparam logic [MATCH_W-1:0]  MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [SEARCH_W-1:0] SEARCH_MAX = SEARCH_W'(TIMEOUT);

   logic [4:0]          v_r;
   logic                sel_r;
   mon_state_t          state_r;
   logic [2:0]          phase_r;
   logic [MATCH_W-1:0]  match_r;
   logic [SEARCH_W-1:0] search_r;
   logic                locked_r;
   logic                phase_err_r;
   logic                stalled_r;
   logic [ERR_W-1:0]    err_count_r;

   mon_state_t          state_next_s;
   logic [2:0]          phase_next_s;
   logic [MATCH_W-1:0]  match_next_s;
   logic [SEARCH_W-1:0] search_next_s;
   logic [ERR_W-1:0]    err_count_next_s;
   logic                stalled_next_s;
   logic                err_pulse_s;
   logic                hit_s;
   logic                sel_chg_s;
   logic [4:0]          exp_v_s;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
      if (cnt == {ERR_W{1'b1}}) begin
         return cnt;
      end else begin
         return cnt + ERR_W'(1);
      end
   endfunction

   clk_pattern_rom u_rom (
      .mode  (sel_r),
      .phase (phase_r),
      .v     (exp_v_s)
   );

   // Next-state, counter and error-pulse logic.
   always_comb begin
      hit_s         = (v_r == exp_v_s);
      sel_chg_s     = (clk_select != sel_r);
      state_next_s  = state_r;
      phase_next_s  = phase_r;
      match_next_s  = match_r;
      search_next_s = '0;
      err_pulse_s   = 1'b0;
      if (sel_chg_s) begin
         // A mode change invalidates any lock; this is not an error.
         state_next_s = SEARCH;
         phase_next_s = 3'd0;
         match_next_s = '0;
      end else begin
         case (state_r)
            SEARCH: begin
               if (v_r == ALIGN_V) begin
                  state_next_s = TRACK;
                  phase_next_s = 3'd1;
                  match_next_s = '0;
               end else if (search_r == SEARCH_MAX) begin
                  search_next_s = search_r;
               end else begin
                  search_next_s = search_r + SEARCH_W'(1);
               end
            end
            TRACK: begin
               // A mismatch on the final count still falls back to SEARCH.
               if (hit_s) begin
                  phase_next_s = phase_r + 3'd1;
                  if (match_r == MATCH_LAST) begin
                     state_next_s = LOCKED;
                  end else begin
                     match_next_s = match_r + MATCH_W'(1);
                  end
               end else begin
                  state_next_s = SEARCH;
                  phase_next_s = 3'd0;
                  match_next_s = '0;
               end
            end
            LOCKED: begin
               if (hit_s) begin
                  phase_next_s = phase_r + 3'd1;
               end else begin
                  state_next_s = SEARCH;
                  phase_next_s = 3'd0;
                  match_next_s = '0;
                  err_pulse_s  = 1'b1;
               end
            end
            default: begin
               state_next_s = SEARCH;
               phase_next_s = 3'd0;
               match_next_s = '0;
            end
         endcase
      end
   end

   // Registered-output values: stall flag and error counter.
   always_comb begin
      stalled_next_s = (state_next_s == SEARCH) && (search_next_s == SEARCH_MAX);
      if (clear_err) begin
         err_count_next_s = '0;
      end else if (err_pulse_s) begin
         err_count_next_s = sat_inc(err_count_r);
      end else begin
         err_count_next_s = err_count_r;
      end
   end

   // Input stage, FSM registers and output stage.
   always_ff @(posedge in_clk) begin
      if (reset) begin
         v_r         <= 5'b00000;
         sel_r       <= 1'b0;
         state_r     <= SEARCH;
         phase_r     <= 3'd0;
         match_r     <= '0;
         search_r    <= '0;
         locked_r    <= 1'b0;
         phase_err_r <= 1'b0;
         stalled_r   <= 1'b0;
         err_count_r <= '0;
      end else begin
         v_r         <= {PCLK_in, nCLKEN_in, BCLK_in, CPUCLK_in, CLK90_in};
         sel_r       <= clk_select;
         state_r     <= state_next_s;
         phase_r     <= phase_next_s;
         match_r     <= match_next_s;
         search_r    <= search_next_s;
         // Follows the current state, so lock is dropped one cycle after the error pulse.
         locked_r    <= (state_r == LOCKED);
         phase_err_r <= err_pulse_s;
         stalled_r   <= stalled_next_s;
         err_count_r <= err_count_next_s;
      end
   end

   assign locked    = locked_r;
   assign phase_err = phase_err_r;
   assign stalled   = stalled_r;
   assign phase_idx = phase_r;
   assign err_count = err_count_r;

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor.
// Each driven cycle pushes the outputs expected 2 edges later onto a
// scoreboard queue. The entry is popped and compared once it has matured.
module tb_clock_monitor;

   logic       in_clk = 1'b0;
   logic       reset;
   logic       clk_select;
   logic [4:0] v_drv;
   logic       clear_err;
   logic       locked;
   logic       phase_err;
   logic       stalled;
   logic [2:0] phase_idx;
   logic [7:0] err_count;

   int checks = 0;
   int errors = 0;
   string cur_test;

   typedef struct packed {
      logic [3:0] m;     // compare mask: [3] locked [2] phase_err [1] stalled [0] err_count
      logic       lk;
      logic       pe;
      logic       st;
      logic [7:0] ec;
      int         idx;
   } exp_t;

   exp_t sb_q[$];

   logic [4:0] pat0 [4] = '{5'b10101, 5'b01100, 5'b11010, 5'b00011};
   logic [4:0] pat1 [8] = '{5'b10101, 5'b01101, 5'b11100, 5'b00100,
                            5'b10010, 5'b01010, 5'b11011, 5'b00011};

   clock_monitor dut (
      .in_clk     (in_clk),
      .reset      (reset),
      .clk_select (clk_select),
      .PCLK_in    (v_drv[4]),
      .nCLKEN_in  (v_drv[3]),
      .BCLK_in    (v_drv[2]),
      .CPUCLK_in  (v_drv[1]),
      .CLK90_in   (v_drv[0]),
      .clear_err  (clear_err),
      .locked     (locked),
      .phase_err  (phase_err),
      .stalled    (stalled),
      .phase_idx  (phase_idx),
      .err_count  (err_count)
   );

   always #5 in_clk = ~in_clk;

   function automatic exp_t mk(input logic [3:0] m, input logic lk, input logic pe,
                               input logic st, input logic [7:0] ec, input int idx);
      exp_t e;
      e.m = m; e.lk = lk; e.pe = pe; e.st = st; e.ec = ec; e.idx = idx;
      return e;
   endfunction

   task automatic do_reset(input logic sel);
      clk_select = sel;
      reset      = 1'b1;
      v_drv      = 5'b00000;
      clear_err  = 1'b0;
      sb_q.delete();
      @(posedge in_clk);
      #1;
      reset = 1'b0;
   endtask

   // Drive one cycle of stimulus, queue its expectation, retire the matured entry.
   task automatic step(input logic sel, input logic [4:0] v, input logic clr, input exp_t e);
      exp_t got;
      clk_select = sel;
      v_drv      = v;
      clear_err  = clr;
      sb_q.push_back(e);
      @(posedge in_clk);
      #1;
      if (sb_q.size() == 2) begin
         got = sb_q.pop_front();
         if (got.m[3]) begin
            checks++;
            if (locked !== got.lk) begin
               errors++;
               $display("FAIL %s[%0d] locked got %0b want %0b", cur_test, got.idx, locked, got.lk);
            end
         end
         if (got.m[2]) begin
            checks++;
            if (phase_err !== got.pe) begin
               errors++;
               $display("FAIL %s[%0d] phase_err got %0b want %0b", cur_test, got.idx, phase_err, got.pe);
            end
         end
         if (got.m[1]) begin
            checks++;
            if (stalled !== got.st) begin
               errors++;
               $display("FAIL %s[%0d] stalled got %0b want %0b", cur_test, got.idx, stalled, got.st);
            end
         end
         if (got.m[0]) begin
            checks++;
            if (err_count !== got.ec) begin
               errors++;
               $display("FAIL %s[%0d] err_count got %0d want %0d", cur_test, got.idx, err_count, got.ec);
            end
         end
      end
   endtask

   task automatic test_reset();
      cur_test   = "reset";
      reset      = 1'b1;
      clk_select = 1'b0;
      clear_err  = 1'b0;
      v_drv      = 5'b10101;
      repeat (2) @(posedge in_clk);
      #1;
      checks += 5;
      if (locked !== 1'b0)    begin errors++; $display("FAIL reset locked got %0b want 0", locked); end
      if (phase_err !== 1'b0) begin errors++; $display("FAIL reset phase_err got %0b want 0", phase_err); end
      if (stalled !== 1'b0)   begin errors++; $display("FAIL reset stalled got %0b want 0", stalled); end
      if (phase_idx !== 3'd0) begin errors++; $display("FAIL reset phase_idx got %0d want 0", phase_idx); end
      if (err_count !== 8'd0) begin errors++; $display("FAIL reset err_count got %0d want 0", err_count); end
      reset = 1'b0;
   endtask

   task automatic test_stall();
      logic [4:0] v;
      cur_test = "stall";
      do_reset(1'b0);
      for (int k = 0; k < 23; k++) begin
         if (k < 20) v = 5'b00000;
         else        v = pat0[k - 20];
         step(1'b0, v, 1'b0, mk(4'b1111, 1'b0, 1'b0, (k >= 14 && k < 20), 8'd0, k));
      end
      step(1'b0, pat0[3], 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b0, 8'd0, 23));
   endtask

   task automatic test_mode0_lock();
      cur_test = "mode0_lock";
      do_reset(1'b0);
      for (int k = 0; k < 30; k++) begin
         step(1'b0, pat0[k % 4], 1'b0, mk(4'b1111, (k >= 17), 1'b0, 1'b0, 8'd0, k));
         checks++;
         if (phase_idx !== 3'(k % 8)) begin
            errors++;
            $display("FAIL mode0_lock[%0d] phase_idx got %0d want %0d", k, phase_idx, k % 8);
         end
      end
      step(1'b0, pat0[2], 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b0, 8'd0, 30));
   endtask

   task automatic test_last_match();
      logic [4:0] v;
      cur_test = "last_match";
      do_reset(1'b0);
      for (int k = 0; k < 41; k++) begin
         v = pat0[k % 4];
         if (k == 16) v = v ^ 5'b00100;
         step(1'b0, v, 1'b0, mk(4'b1111, (k >= 37), 1'b0, 1'b0, 8'd0, k));
      end
      step(1'b0, pat0[1], 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b0, 8'd0, 41));
   endtask

   task automatic test_mode1_error();
      logic [4:0] v;
      cur_test = "mode1_error";
      do_reset(1'b1);
      for (int k = 0; k < 56; k++) begin
         v = pat1[k % 8];
         if (k == 27) v = v ^ 5'b00100;
         step(1'b1, v, 1'b0, mk(4'b1111, ((k >= 17 && k <= 27) || k >= 49), (k == 27),
                                1'b0, (k >= 27) ? 8'd1 : 8'd0, k));
      end
      step(1'b1, pat1[0], 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b0, 8'd0, 56));
   endtask

   task automatic test_sel_switch();
      cur_test = "sel_switch";
      do_reset(1'b0);
      for (int k = 0; k < 61; k++) begin
         if (k < 20) step(1'b0, pat0[k % 4], 1'b0,
                          mk(4'b1111, (k >= 17), 1'b0, 1'b0, 8'd0, k));
         else        step(1'b1, pat1[(k - 20) % 8], 1'b0,
                          mk(4'b1111, (k == 20) ? 1'b0 : (k >= 37), 1'b0, 1'b0, 8'd0, k));
      end
      step(1'b1, pat1[1], 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b0, 8'd0, 61));
   endtask

   task automatic test_reset_locked();
      cur_test = "reset_locked";
      do_reset(1'b0);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, pat0[k % 4], 1'b0, mk(4'b1111, (k >= 17), 1'b0, 1'b0, 8'd0, k));
      end
      // Corrupt sample whose compare edge coincides with the reset edge.
      step(1'b0, pat0[0] ^ 5'b00100, 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b0, 8'd0, 20));
      reset = 1'b1;
      v_drv = pat0[1];
      @(posedge in_clk);
      #1;
      reset = 1'b0;
      sb_q.delete();
      checks += 6;
      if (locked !== 1'b0)    begin errors++; $display("FAIL reset_locked locked got %0b want 0", locked); end
      if (phase_err !== 1'b0) begin errors++; $display("FAIL reset_locked phase_err got %0b want 0", phase_err); end
      if (stalled !== 1'b0)   begin errors++; $display("FAIL reset_locked stalled got %0b want 0", stalled); end
      if (phase_idx !== 3'd0) begin errors++; $display("FAIL reset_locked phase_idx got %0d want 0", phase_idx); end
      if (err_count !== 8'd0) begin errors++; $display("FAIL reset_locked err_count got %0d want 0", err_count); end
      v_drv = pat0[2];
      @(posedge in_clk);
      #1;
      if (phase_err !== 1'b0) begin errors++; $display("FAIL reset_locked late phase_err got %0b want 0", phase_err); end
   endtask

   task automatic test_saturate();
      logic [4:0] v;
      int ne;
      cur_test = "saturate";
      do_reset(1'b0);
      // Each 20-cycle round: align, lock, then corrupt the last sample.
      for (int n = 0; n <= 300; n++) begin
         for (int j = 0; j < 20; j++) begin
            v  = pat0[j % 4];
            if (j == 19) v = v ^ 5'b00100;
            ne = n + ((j == 19) ? 1 : 0);
            if (ne > 255) ne = 255;
            if (n == 300 && j == 19) ne = 0;
            step(1'b0, v, 1'b0, mk(4'b1111, (j >= 17), (j == 19), 1'b0, 8'(ne), n * 20 + j));
         end
      end
      // clear_err lands on the compare edge of the 301st error.
      step(1'b0, pat0[0], 1'b1, mk(4'b1111, 1'b0, 1'b0, 1'b0, 8'd0, 6020));
      step(1'b0, pat0[1], 1'b0, mk(4'b0000, 1'b0, 1'b0, 1'b0, 8'd0, 6021));
      checks++;
      if (err_count !== 8'd0) begin
         errors++;
         $display("FAIL saturate final err_count got %0d want 0", err_count);
      end
   endtask

   initial begin
      reset      = 1'b1;
      clk_select = 1'b0;
      clear_err  = 1'b0;
      v_drv      = 5'b00000;
      test_reset();
      test_stall();
      test_mode0_lock();
      test_last_match();
      test_mode1_error();
      test_sel_switch();
      test_reset_locked();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
